// File: rtl/muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide sequencer: op codes, FSM states,
// default operand width and small op-decode helpers.
package muldiv_pkg;

  localparam int W_DEFAULT = 32;

  localparam logic [2:0] OP_MUL   = 3'd0;
  localparam logic [2:0] OP_MULU  = 3'd1;
  localparam logic [2:0] OP_MADD  = 3'd2;
  localparam logic [2:0] OP_MADDU = 3'd3;
  localparam logic [2:0] OP_DIV   = 3'd4;
  localparam logic [2:0] OP_DIVU  = 3'd5;
  localparam logic [2:0] OP_MTHI  = 3'd6;
  localparam logic [2:0] OP_MTLO  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_run_op(input logic [2:0] op);
    return op <= OP_DIVU;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_madd_op(input logic [2:0] op);
    return (op == OP_MADD) || (op == OP_MADDU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_MADD) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the core and the mul/div sequencer; the core is the master.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) ();
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         busy;
  logic         stall;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, src_a, src_b,
    input  busy, stall, done, div_by_zero, hi, lo
  );

  modport slave (
    input  start, op, src_a, src_b,
    output busy, stall, done, div_by_zero, hi, lo
  );
endinterface

// File: rtl/muldiv_operand_cond.sv
// Sign-magnitude conditioning of rs/rt and the result-negation flags for the iterative datapath.
// The remainder-sign flag is only present when MULDIV_DIV_EN is defined.
module muldiv_operand_cond
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [W-1:0] src_a,
  input  logic [W-1:0] src_b,
  input  logic         is_signed,
  output logic [W-1:0] mag_a,
  output logic [W-1:0] mag_b,
`ifdef MULDIV_DIV_EN
  output logic         neg_rem,
`endif
  output logic         neg_res
);
  logic signed [W-1:0] sa;
  logic signed [W-1:0] sb;
  logic                a_neg;
  logic                b_neg;

  // Magnitude of -2^(W-1) is 2^(W-1), which still fits the unsigned W-bit result.
  always_comb begin
    sa      = signed'(src_a);
    sb      = signed'(src_b);
    a_neg   = is_signed & sa[W-1];
    b_neg   = is_signed & sb[W-1];
    mag_a   = a_neg ? unsigned'(-sa) : src_a;
    mag_b   = b_neg ? unsigned'(-sb) : src_b;
    neg_res = a_neg ^ b_neg;
`ifdef MULDIV_DIV_EN
    neg_rem = a_neg;
`endif
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative shift-add multiplier / restoring divider owning HI/LO, one bit per cycle.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU complete at once with HI/LO untouched.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int CNT_W = $clog2(W + 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;
  logic [W-1:0]     opb_q;
  logic [W-1:0]     mag_a;
  logic [W-1:0]     mag_b;
  logic [2*W-1:0]   acc_q;
  logic [2*W-1:0]   acc_step;
  logic [2*W-1:0]   res;
  logic [W:0]       mul_sum;
  logic             madd_q;
  logic             neg_res_q;
  logic             neg_res;
  logic             dz_q;
  logic             issue;
  logic             bypass;
  logic             last;
  logic             busy_c;
  logic             stall_c;
  logic             done_c;
`ifdef MULDIV_DIV_EN
  logic             div_q;
  logic             neg_rem_q;
  logic             neg_rem;
  logic [W:0]       rem_sh;
  logic             rem_ge;
  logic [W-1:0]     quo;
  logic [W-1:0]     rem;
`endif

  assign issue = (state_q == ST_IDLE) && bus.start && is_run_op(bus.op);
`ifdef MULDIV_DIV_EN
  assign bypass = is_div_op(bus.op) && (bus.src_b == '0);
`else
  assign bypass = is_div_op(bus.op);
`endif
  assign last = (cnt_q == CNT_W'(1));

  muldiv_operand_cond #(.W(W)) u_cond (
    .src_a     (bus.src_a),
    .src_b     (bus.src_b),
    .is_signed (is_signed_op(bus.op)),
    .mag_a     (mag_a),
    .mag_b     (mag_b),
`ifdef MULDIV_DIV_EN
    .neg_rem   (neg_rem),
`endif
    .neg_res   (neg_res)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy_c  = 1'b0;
    stall_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (issue) begin
          stall_c = 1'b1;
          state_d = bypass ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        busy_c  = 1'b1;
        stall_c = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_c  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Iteration: multiply shifts right adding the multiplicand; divide shifts left trial-subtracting.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    acc_step = {mul_sum, acc_q[W-1:1]};
`ifdef MULDIV_DIV_EN
    rem_sh = {acc_q[2*W-1:W], acc_q[W-1]};
    rem_ge = rem_sh >= {1'b0, opb_q};
    if (div_q) begin
      acc_step = {(rem_ge ? rem_sh[W-1:0] - opb_q : rem_sh[W-1:0]), acc_q[W-2:0], rem_ge};
    end
`endif
  end

  // Final edge: restore signs and accumulate into HI/LO.
  always_comb begin
    res = neg_res_q ? -acc_step : acc_step;
    if (madd_q) res = {hi_q, lo_q} + res;
`ifdef MULDIV_DIV_EN
    quo = acc_step[W-1:0];
    rem = acc_step[2*W-1:W];
    if (div_q) res = {(neg_rem_q ? -rem : rem), (neg_res_q ? -quo : quo)};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      dz_q  <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (issue)                  cnt_q <= CNT_W'(W);
      else if (state_q == ST_RUN) cnt_q <= cnt_q - CNT_W'(1);
`ifdef MULDIV_DIV_EN
      if (state_q == ST_IDLE) dz_q <= issue && bypass;
`else
      dz_q <= 1'b0;
`endif
      if ((state_q == ST_IDLE) && bus.start && (bus.op == OP_MTHI)) hi_q <= bus.src_a;
      if ((state_q == ST_IDLE) && bus.start && (bus.op == OP_MTLO)) lo_q <= bus.src_a;
      if ((state_q == ST_RUN) && last) {hi_q, lo_q} <= res;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      acc_q     <= {{W{1'b0}}, mag_a};
      opb_q     <= mag_b;
      neg_res_q <= neg_res;
      madd_q    <= is_madd_op(bus.op);
`ifdef MULDIV_DIV_EN
      div_q     <= is_div_op(bus.op);
      neg_rem_q <= neg_rem;
`endif
    end else if (state_q == ST_RUN) begin
      acc_q <= acc_step;
    end
  end

  assign bus.busy        = busy_c;
  assign bus.stall       = stall_c;
  assign bus.done        = done_c;
  assign bus.div_by_zero = done_c & dz_q;
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
